hs32_scoreboard: RTL and testbench
==================================

Name: hs32_scoreboard

Overview:
Register-hazard controller that sequences issue into the hs32 execute stage. Tracks in-flight load destinations per architectural register and computes the decode-stage stall. Generates the d1 forwarding select consumed by the execute stage's fwd field. Sits between decode (issue side) and execute/LSU (retire side); owns no datapath, only control.

Parameters:
MAX_OUTSTANDING, 4, max loads in flight across all registers (1..15)
RETIRE_BYPASS, 1, 1 = load retiring this cycle satisfies a same-cycle RAW check (LSU data forwarded); 0 = stall one extra cycle

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
issue_vld_i  input  1  decode presents an instruction this cycle
issue_rd_i  input  4  destination register
issue_we_i  input  1  instruction writes rd
issue_ld_i  input  1  instruction is a load (rd written at LSU retire)
issue_rs1_i  input  4  source 1 register (feeds d1)
issue_rs1_used_i  input  1  rs1 is read
issue_rs2_i  input  4  source 2 register
issue_rs2_used_i  input  1  rs2 is read
ex_vld_i  input  1  execute stage holds a valid instruction
ex_rd_i  input  4  execute stage destination
ex_we_i  input  1  execute stage writes rd via ALU (non-load)
ret_vld_i  input  1  LSU load data returned to regfile this cycle
ret_rd_i  input  4  register of returning load
flush_i  input  1  discard all in-flight tracking
stall_o  output  1  decode must hold; issue not accepted
fwd_o  output  1  d1 of the issuing instruction comes from execute result
busy_o  output  16  per-register pending-load mask
cnt_o  output  4  total loads in flight
err_o  output  1  sticky: retire to non-pending register, or counter overflow

Behaviour:
- Interface: one clock, clk; reset synchronous, active-high; all state updates on rising clk.
- Reset: all per-register counters 0, cnt_o 0, busy_o 0, err_o 0. stall_o and fwd_o are combinational; with issue_vld_i low they are 0.
- State: per-register counter pend[r], width clog2(MAX_OUTSTANDING+1); busy_o[r] = (pend[r] != 0); cnt_o = sum of pend, held as a separate register.
- Pending check: p(r) = busy_o[r] and not (RETIRE_BYPASS and ret_vld_i and ret_rd_i==r and pend[r]==1).
- stall_o = issue_vld_i and any of:
  - RAW: rs1_used and p(rs1); rs2_used and p(rs2).
  - WAW: issue_we_i and p(rd).
  - Capacity: issue_ld_i and issue_we_i and cnt_o == MAX_OUTSTANDING, and no retire this cycle.
  - Load-use: rs2_used and ex_vld_i and ex_rd_i==rs2 and the instruction in execute is a load; this case is already covered by pend (load counted at issue).
- fwd_o = issue_vld_i and not stall_o and issue_rs1_used_i and ex_vld_i and ex_we_i and ex_rd_i==issue_rs1_i. rs2 is never forwarded; an rs2 match with an ALU write in execute sets stall_o for one cycle.
- Accepted issue = issue_vld_i and not stall_o. If it is a writing load, pend[rd]++ and cnt++ at the next edge.
- Retire with ret_vld_i: pend[ret_rd_i]--, cnt--. If pend[ret_rd_i]==0, no decrement and err_o is set.
- Simultaneous issue and retire on the same register: net counter change 0; cnt unchanged.
- Overflow guard: increment when pend==MAX is impossible under the capacity stall. If it occurs anyway, the counter saturates and err_o is set.
- flush_i: next cycle all pend=0 and cnt=0; err_o retained. Same-cycle issue/retire are ignored. stall_o is still computed from the pre-flush state.
- Reset mid-operation: overrides flush, issue and retire; clears err_o.
- Latency: tracking is visible on stall_o one cycle after acceptance (registered counters). stall_o/fwd_o are 0-cycle combinational from issue inputs.

Decomposition:
- hs32_pkg additions: HS32_NREGS=16, typedef hs32_reg_t (logic[3:0]), typedef hs32_issue_t struct {rd, rs1, rs2, we, ld, rs1_used, rs2_used}.
- The scoreboard uses hs32_issue_t internally; ports stay flat.
- One sub-module, hs32_sb_cnt: a single saturating up/down counter with inc, dec and clr inputs, a nonzero output and an error pulse. The top generates 16 instances.

Test Plan:
1. Reset, then issue load to r3 (vld, we, ld) -> next cycle busy_o=0x0008, cnt_o=1; issue an instruction with rs1=r3 -> stall_o=1.
2. With r3 pending (count 1), ret_vld_i=1, ret_rd_i=3 while issuing rs1=r3 -> RETIRE_BYPASS=1: stall_o=0; RETIRE_BYPASS=0: stall_o=1; next cycle busy_o=0.
3. Execute holds ALU write to r5 (ex_vld, ex_we, ex_rd=5); issue rs1=r5 -> fwd_o=1, stall_o=0. Same with rs2=r5 -> stall_o=1, fwd_o=0.
4. Issue 4 loads to r1, r2, r4, r6 (MAX=4) -> cnt_o=4; a 5th load to r7 -> stall_o=1. Assert ret r1 in the same cycle -> stall_o=0; next cycle cnt_o=4, busy_o=0x00D4.
5. Loads to r2 then r2 -> second issue stalls (WAW). Retire r2 twice -> second retire sets err_o=1 (sticky), pend stays 0.
6. Two loads pending, flush_i=1 with a concurrent load issue -> next cycle cnt_o=0, busy_o=0, err_o unchanged. Reset asserted -> err_o=0.

Source files
------------

// File: rtl/hs32_pkg.sv
// Shared hs32 types: architectural register index and the decoded issue record.
package hs32_pkg;

  localparam int HS32_NREGS = 16;

  typedef logic [3:0] hs32_reg_t;

  typedef struct packed {
    hs32_reg_t rd;
    hs32_reg_t rs1;
    hs32_reg_t rs2;
    logic      we;
    logic      ld;
    logic      rs1_used;
    logic      rs2_used;
  } hs32_issue_t;

endpackage

// File: rtl/hs32_scoreboard_if.sv
// Decode/execute/LSU <-> scoreboard control bundle; master drives issue and retire.
interface hs32_scoreboard_if;
  import hs32_pkg::*;

  logic                  issue_vld_i;
  hs32_reg_t             issue_rd_i;
  logic                  issue_we_i;
  logic                  issue_ld_i;
  hs32_reg_t             issue_rs1_i;
  logic                  issue_rs1_used_i;
  hs32_reg_t             issue_rs2_i;
  logic                  issue_rs2_used_i;
  logic                  ex_vld_i;
  hs32_reg_t             ex_rd_i;
  logic                  ex_we_i;
  logic                  ret_vld_i;
  hs32_reg_t             ret_rd_i;
  logic                  flush_i;
  logic                  stall_o;
  logic                  fwd_o;
  logic [HS32_NREGS-1:0] busy_o;
  logic [3:0]            cnt_o;
  logic                  err_o;

  modport master (
    output issue_vld_i, issue_rd_i, issue_we_i, issue_ld_i, issue_rs1_i,
           issue_rs1_used_i, issue_rs2_i, issue_rs2_used_i, ex_vld_i, ex_rd_i,
           ex_we_i, ret_vld_i, ret_rd_i, flush_i,
    input  stall_o, fwd_o, busy_o, cnt_o, err_o
  );

  modport slave (
    input  issue_vld_i, issue_rd_i, issue_we_i, issue_ld_i, issue_rs1_i,
           issue_rs1_used_i, issue_rs2_i, issue_rs2_used_i, ex_vld_i, ex_rd_i,
           ex_we_i, ret_vld_i, ret_rd_i, flush_i,
    output stall_o, fwd_o, busy_o, cnt_o, err_o
  );

endinterface

// File: rtl/hs32_sb_cnt.sv
// Saturating up/down pending-load counter for one register; err pulses on
// decrement at zero or increment at MAX.
module hs32_sb_cnt #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         nonzero,
  output logic         err
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic dec_ok;
  logic inc_ok;

  // A decrement at MAX frees the slot, so a same-cycle increment still fits.
  assign dec_ok  = dec && (cnt != '0);
  assign inc_ok  = inc && ((cnt != MAX_V) || dec_ok);
  assign nonzero = (cnt != '0);
  assign err     = (dec && !dec_ok) || (inc && !inc_ok);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) so every register samples the same pre-edge state.
    if (reset || clr)          cnt <= '0;
    else if (inc_ok && !dec_ok) cnt <= cnt + 1'b1;
    else if (dec_ok && !inc_ok) cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/hs32_scoreboard.sv
// hs32 register-hazard scoreboard: tracks in-flight loads per register and
// produces the decode stall and the execute d1 forwarding select.
module hs32_scoreboard
  import hs32_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter bit RETIRE_BYPASS   = 1'b1
) (
  input logic               clk,
  input logic               reset,
  hs32_scoreboard_if.slave  sb
);

  localparam int         PW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [3:0] CNT_MAX = 4'(MAX_OUTSTANDING);

  hs32_issue_t           iss;
  logic [PW-1:0]         pend [HS32_NREGS];
  logic [HS32_NREGS-1:0] busy, pending, inc, dec, cnt_err;
  logic [3:0]            cnt;
  logic                  err;
  logic                  raw, waw, cap, ex_rs2, stall, fwd;
  logic                  ld_acc, cnt_inc, cnt_dec, cnt_ovf;

  assign iss = '{rd: sb.issue_rd_i, rs1: sb.issue_rs1_i, rs2: sb.issue_rs2_i,
                 we: sb.issue_we_i, ld: sb.issue_ld_i,
                 rs1_used: sb.issue_rs1_used_i, rs2_used: sb.issue_rs2_used_i};

  for (genvar r = 0; r < HS32_NREGS; r++) begin : g_reg
    hs32_sb_cnt #(.MAX(MAX_OUTSTANDING), .W(PW)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc[r]),
      .dec     (dec[r]),
      .clr     (sb.flush_i),
      .cnt     (pend[r]),
      .nonzero (busy[r]),
      .err     (cnt_err[r])
    );
    // The last outstanding load returning now already has its data forwarded.
    assign pending[r] = busy[r] && !(RETIRE_BYPASS && sb.ret_vld_i &&
                        (sb.ret_rd_i == hs32_reg_t'(r)) && (pend[r] == PW'(1)));
    assign inc[r] = ld_acc && (iss.rd == hs32_reg_t'(r));
    assign dec[r] = !sb.flush_i && sb.ret_vld_i && (sb.ret_rd_i == hs32_reg_t'(r));
  end

  always_comb begin
    // NOTE: every output is assigned on every path, so no latch is inferred.
    raw    = (iss.rs1_used && pending[iss.rs1]) || (iss.rs2_used && pending[iss.rs2]);
    waw    = iss.we && pending[iss.rd];
    cap    = iss.ld && iss.we && (cnt == CNT_MAX) && !sb.ret_vld_i;
    ex_rs2 = iss.rs2_used && sb.ex_vld_i && sb.ex_we_i && (sb.ex_rd_i == iss.rs2);
    stall  = sb.issue_vld_i && (raw || waw || cap || ex_rs2);
    fwd    = sb.issue_vld_i && !stall && iss.rs1_used && sb.ex_vld_i &&
             sb.ex_we_i && (sb.ex_rd_i == iss.rs1);
  end

  // Flush discards same-cycle issue and retire.
  assign ld_acc  = sb.issue_vld_i && !stall && iss.ld && iss.we && !sb.flush_i;
  assign cnt_dec = !sb.flush_i && sb.ret_vld_i && busy[sb.ret_rd_i];
  assign cnt_inc = ld_acc && ((cnt != CNT_MAX) || cnt_dec);
  assign cnt_ovf = ld_acc && !cnt_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (sb.flush_i)               cnt <= '0;
      else if (cnt_inc && !cnt_dec) cnt <= cnt + 4'd1;
      else if (cnt_dec && !cnt_inc) cnt <= cnt - 4'd1;
      if ((|cnt_err) || cnt_ovf)    err <= 1'b1;
    end
  end

  assign sb.stall_o = stall;
  assign sb.fwd_o   = fwd;
  assign sb.busy_o  = busy;
  assign sb.cnt_o   = cnt;
  assign sb.err_o   = err;

endmodule

// File: tb/tb_hs32_scoreboard.sv
// Directed table-driven bench for hs32_scoreboard; a second instance with
// RETIRE_BYPASS=0 shadows the same stimulus.
module tb_hs32_scoreboard;
  import hs32_pkg::*;

  typedef struct {
    string     name;
    logic      vld, we, ld;
    hs32_reg_t rd;
    hs32_reg_t rs1;
    logic      rs1_used;
    hs32_reg_t rs2;
    logic      rs2_used;
    logic      ex_vld, ex_we;
    hs32_reg_t ex_rd;
    logic      ret_vld;
    hs32_reg_t ret_rd;
    logic      flush;
    logic      stall, fwd, stall_nb;
    logic [15:0] busy;
    logic [3:0]  cnt;
    logic        err;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  hs32_scoreboard_if sb ();
  hs32_scoreboard_if sb0 ();

  hs32_scoreboard #(.MAX_OUTSTANDING(4), .RETIRE_BYPASS(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb.slave)
  );

  hs32_scoreboard #(.MAX_OUTSTANDING(4), .RETIRE_BYPASS(1'b0)) dut_nb (
    .clk   (clk),
    .reset (reset),
    .sb    (sb0.slave)
  );

  assign sb0.issue_vld_i      = sb.issue_vld_i;
  assign sb0.issue_rd_i       = sb.issue_rd_i;
  assign sb0.issue_we_i       = sb.issue_we_i;
  assign sb0.issue_ld_i       = sb.issue_ld_i;
  assign sb0.issue_rs1_i      = sb.issue_rs1_i;
  assign sb0.issue_rs1_used_i = sb.issue_rs1_used_i;
  assign sb0.issue_rs2_i      = sb.issue_rs2_i;
  assign sb0.issue_rs2_used_i = sb.issue_rs2_used_i;
  assign sb0.ex_vld_i         = sb.ex_vld_i;
  assign sb0.ex_rd_i          = sb.ex_rd_i;
  assign sb0.ex_we_i          = sb.ex_we_i;
  assign sb0.ret_vld_i        = sb.ret_vld_i;
  assign sb0.ret_rd_i         = sb.ret_rd_i;
  assign sb0.flush_i          = sb.flush_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string n,
    input logic vld, we, ld, input hs32_reg_t rd,
    input hs32_reg_t rs1, input logic r1u, input hs32_reg_t rs2, input logic r2u,
    input logic exv, exw, input hs32_reg_t exrd,
    input logic rv, input hs32_reg_t rrd, input logic fl,
    input logic es, ef, es0, input logic [15:0] eb, input logic [3:0] ec, input logic ee);
    vec_t v;
    v.name = n; v.vld = vld; v.we = we; v.ld = ld; v.rd = rd;
    v.rs1 = rs1; v.rs1_used = r1u; v.rs2 = rs2; v.rs2_used = r2u;
    v.ex_vld = exv; v.ex_we = exw; v.ex_rd = exrd;
    v.ret_vld = rv; v.ret_rd = rrd; v.flush = fl;
    v.stall = es; v.fwd = ef; v.stall_nb = es0; v.busy = eb; v.cnt = ec; v.err = ee;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    sb.issue_vld_i      = v.vld;
    sb.issue_we_i       = v.we;
    sb.issue_ld_i       = v.ld;
    sb.issue_rd_i       = v.rd;
    sb.issue_rs1_i      = v.rs1;
    sb.issue_rs1_used_i = v.rs1_used;
    sb.issue_rs2_i      = v.rs2;
    sb.issue_rs2_used_i = v.rs2_used;
    sb.ex_vld_i         = v.ex_vld;
    sb.ex_we_i          = v.ex_we;
    sb.ex_rd_i          = v.ex_rd;
    sb.ret_vld_i        = v.ret_vld;
    sb.ret_rd_i         = v.ret_rd;
    sb.flush_i          = v.flush;
  endtask

  initial begin
    vec_t idle;
    n_checks = 0;
    n_fail   = 0;
    idle = mk("idle", 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h0000,0,0);

    // Columns: name | vld we ld rd | rs1 r1u rs2 r2u | exv exw exrd | rv rrd fl |
    //          stall fwd stall(no bypass) | busy cnt err (state before this edge)
    vecs.push_back(mk("reset_idle",   0,0,0,0,  0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h0000,0,0));
    vecs.push_back(mk("ld_r3",        1,1,1,3,  0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h0000,0,0));
    vecs.push_back(mk("raw_rs1_r3",   1,0,0,0,  3,1,0,0, 0,0,0, 0,0,0, 1,0,1, 16'h0008,1,0));
    vecs.push_back(mk("raw_rs2_r3",   1,0,0,0,  0,0,3,1, 0,0,0, 0,0,0, 1,0,1, 16'h0008,1,0));
    vecs.push_back(mk("ret_bypass",   1,0,0,0,  3,1,0,0, 0,0,0, 1,3,0, 0,0,1, 16'h0008,1,0));
    vecs.push_back(mk("fwd_rs1_r5",   1,0,0,0,  5,1,0,0, 1,1,5, 0,0,0, 0,1,0, 16'h0000,0,0));
    vecs.push_back(mk("ex_rs2_stall", 1,0,0,0,  0,0,5,1, 1,1,5, 0,0,0, 1,0,1, 16'h0000,0,0));
    vecs.push_back(mk("no_fwd_ex_ld", 1,0,0,0,  5,1,0,0, 1,0,5, 0,0,0, 0,0,0, 16'h0000,0,0));
    vecs.push_back(mk("no_fwd_unusd", 1,0,0,0,  5,0,0,0, 1,1,5, 0,0,0, 0,0,0, 16'h0000,0,0));
    vecs.push_back(mk("ld_r1",        1,1,1,1,  0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h0000,0,0));
    vecs.push_back(mk("ld_r2",        1,1,1,2,  0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h0002,1,0));
    vecs.push_back(mk("ld_r4",        1,1,1,4,  0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h0006,2,0));
    vecs.push_back(mk("ld_r6",        1,1,1,6,  0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h0016,3,0));
    vecs.push_back(mk("cap_r7",       1,1,1,7,  0,0,0,0, 0,0,0, 0,0,0, 1,0,1, 16'h0056,4,0));
    vecs.push_back(mk("cap_r7_ret1",  1,1,1,7,  0,0,0,0, 0,0,0, 1,1,0, 0,0,0, 16'h0056,4,0));
    vecs.push_back(mk("after_ret1",   0,0,0,0,  0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h00D4,4,0));
    vecs.push_back(mk("ret_r2",       0,0,0,0,  0,0,0,0, 0,0,0, 1,2,0, 0,0,0, 16'h00D4,4,0));
    vecs.push_back(mk("ret_r4",       0,0,0,0,  0,0,0,0, 0,0,0, 1,4,0, 0,0,0, 16'h00D0,3,0));
    vecs.push_back(mk("ret_r6",       0,0,0,0,  0,0,0,0, 0,0,0, 1,6,0, 0,0,0, 16'h00C0,2,0));
    vecs.push_back(mk("ret_r7",       0,0,0,0,  0,0,0,0, 0,0,0, 1,7,0, 0,0,0, 16'h0080,1,0));
    vecs.push_back(mk("ld_r2_first",  1,1,1,2,  0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h0000,0,0));
    vecs.push_back(mk("ld_r2_waw",    1,1,1,2,  0,0,0,0, 0,0,0, 0,0,0, 1,0,1, 16'h0004,1,0));
    vecs.push_back(mk("alu_r2_waw",   1,1,0,2,  0,0,0,0, 0,0,0, 0,0,0, 1,0,1, 16'h0004,1,0));
    vecs.push_back(mk("ret_r2_ok",    0,0,0,0,  0,0,0,0, 0,0,0, 1,2,0, 0,0,0, 16'h0004,1,0));
    vecs.push_back(mk("ret_r2_err",   0,0,0,0,  0,0,0,0, 0,0,0, 1,2,0, 0,0,0, 16'h0000,0,0));
    vecs.push_back(mk("err_sticky",   0,0,0,0,  0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h0000,0,1));
    vecs.push_back(mk("ld_r8",        1,1,1,8,  0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h0000,0,1));
    vecs.push_back(mk("ld_r9",        1,1,1,9,  0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h0100,1,1));
    vecs.push_back(mk("flush_ld_r10", 1,1,1,10, 0,0,0,0, 0,0,0, 1,8,1, 0,0,0, 16'h0300,2,1));
    vecs.push_back(mk("post_flush",   0,0,0,0,  0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h0000,0,1));

    drive(idle);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check({vecs[i].name, ".stall"},    32'(sb.stall_o),  32'(vecs[i].stall));
      check({vecs[i].name, ".fwd"},      32'(sb.fwd_o),    32'(vecs[i].fwd));
      check({vecs[i].name, ".stall_nb"}, 32'(sb0.stall_o), 32'(vecs[i].stall_nb));
      check({vecs[i].name, ".busy"},     32'(sb.busy_o),   32'(vecs[i].busy));
      check({vecs[i].name, ".cnt"},      32'(sb.cnt_o),    32'(vecs[i].cnt));
      check({vecs[i].name, ".err"},      32'(sb.err_o),    32'(vecs[i].err));
    end

    // Reset mid-operation beats concurrent issue and retire, and clears err.
    @(negedge clk);
    drive(mk("rst_ld_r3", 1,1,1,3, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 16'h0,0,0));
    @(negedge clk);
    drive(mk("rst_mixed", 1,1,1,4, 0,0,0,0, 0,0,0, 1,3,0, 0,0,0, 16'h0,0,0));
    #1;
    check("rst_pre.busy", 32'(sb.busy_o), 32'h0008);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(idle);
    #1;
    check("rst_mid.busy",   32'(sb.busy_o),  32'h0000);
    check("rst_mid.cnt",    32'(sb.cnt_o),   32'h0);
    check("rst_mid.err",    32'(sb.err_o),   32'h0);
    check("rst_mid.err_nb", 32'(sb0.err_o),  32'h0);
    check("rst_mid.stall",  32'(sb.stall_o), 32'h0);
    check("rst_mid.fwd",    32'(sb.fwd_o),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
